// File: rtl/jt900h_dump_rd_pkg.sv
// Shared constants and state encoding for the JT900H register-dump reader.
// Dump map: 0-63 accumulators, 64-79 pointers, 80-81 SR high/low.
package jt900h_dump_rd_pkg;

    localparam logic [7:0] HDR_BYTE      = 8'hD9;
    localparam logic [7:0] LAST_ADDR_DEF = 8'd81;
    localparam int         FRAME_LEN     = 84;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Two's-complement byte, so that adding it to the running sum yields zero.
    function automatic logic [7:0] chk_byte(input logic [7:0] sum);
        return 8'd0 - sum;
    endfunction

endpackage

// File: rtl/jt900h_dump_rd_if.sv
// Dump-port and byte-stream signals shared between the reader, the CPU and the sink.
interface jt900h_dump_rd_if;

    logic [7:0] dmp_addr;
    logic [7:0] dmp_dout;
    logic [7:0] st_data;
    logic       st_valid;
    logic       st_ready;

    modport master (
        output dmp_addr,
        input  dmp_dout,
        output st_data,
        output st_valid,
        input  st_ready
    );

    modport slave (
        input  dmp_addr,
        output dmp_dout,
        input  st_data,
        input  st_valid,
        output st_ready
    );

endinterface

// File: rtl/jt900h_dump_rd.sv
// Sweeps the CPU dump port and streams header, dump bytes and a zero-sum checksum.
// FETCH always spends one non-valid cycle so dmp_dout is sampled on a settled address.
module jt900h_dump_rd
    import jt900h_dump_rd_pkg::*;
#(
    parameter logic [7:0] HDR       = HDR_BYTE,
    parameter logic [7:0] LAST_ADDR = LAST_ADDR_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    jt900h_dump_rd_if.master        bus
);

    state_t     state_r;
    logic [7:0] sum_r;
    logic       xfer_s;

    assign xfer_s = bus.st_valid & bus.st_ready;

    // Frame sequencer; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            sum_r        <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            bus.st_valid <= 1'b0;
            bus.st_data  <= 8'd0;
            bus.dmp_addr <= 8'd0;
        end else if (cen) begin
            done <= 1'b0;
            if (abort) begin
                // Abort beats both start in IDLE and any pending transfer.
                state_r      <= ST_IDLE;
                busy         <= 1'b0;
                bus.st_valid <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            state_r      <= ST_HDR;
                            busy         <= 1'b1;
                            bus.st_valid <= 1'b1;
                            bus.st_data  <= HDR;
                            sum_r        <= HDR;
                            bus.dmp_addr <= 8'd0;
                        end
                    end
                    ST_HDR: begin
                        if (xfer_s) begin
                            state_r      <= ST_FETCH;
                            bus.st_valid <= 1'b0;
                        end
                    end
                    ST_FETCH: begin
                        state_r      <= ST_SEND;
                        bus.st_data  <= bus.dmp_dout;
                        sum_r        <= sum_r + bus.dmp_dout;
                        bus.st_valid <= 1'b1;
                    end
                    ST_SEND: begin
                        if (xfer_s) begin
                            if (bus.dmp_addr == LAST_ADDR) begin
                                state_r     <= ST_CHK;
                                bus.st_data <= chk_byte(sum_r);
                            end else begin
                                state_r      <= ST_FETCH;
                                bus.dmp_addr <= bus.dmp_addr + 8'd1;
                                bus.st_valid <= 1'b0;
                            end
                        end
                    end
                    ST_CHK: begin
                        if (xfer_s) begin
                            state_r      <= ST_DONE;
                            bus.st_valid <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        busy         <= 1'b0;
                        bus.st_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
